ball_sequencer: RTL
===================

BALL_SEQUENCER -- requirements
Module: ball_sequencer

Interface
REQ-001 Parameter NUM_BALLS, default 4, number of balls held in the internal state file (legal range 1..8).
REQ-002 Parameter SCREEN_WIDTH, default 800, visible width in pixels.
REQ-003 Parameter SCREEN_HEIGHT, default 600, visible height in lines.
REQ-004 Parameter BALL_SIZE, default 128, sprite edge length in pixels.
REQ-005 Port clk_50mhz, input, 1, sole clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1, synchronous active-high reset.
REQ-007 Port v_sync, input, 1, active-low vertical sync from the VGA timing generator, synchronous to clk_50mhz.
REQ-008 Port rd_idx, input, 3, ball index for the read port; only the low bits covering NUM_BALLS are used.
REQ-009 Port rd_x, output, 10, committed x position of ball rd_idx, combinational from the state file.
REQ-010 Port rd_y, output, 10, committed y position of ball rd_idx, combinational from the state file.
REQ-011 Port busy, output, 1, high while an update sweep is in progress.
REQ-012 Port frame_done, output, 1, one-cycle pulse when a sweep completes.
REQ-013 Port overrun, output, 1, sticky flag: a frame trigger arrived while busy.

Function
REQ-014 Trigger: v_sync is registered into v_sync_q; trigger is asserted in the cycle where v_sync_q=1 and v_sync=0 (falling edge).
REQ-015 FSM states: IDLE, STEP_X, STEP_Y, DONE; encoding is free.
REQ-016 In IDLE, a trigger moves to STEP_X with ball index 0 on the next edge and sets busy.
REQ-017 STEP_X: one cycle; the shared adder updates x and vx of the current ball; next state is STEP_Y.
REQ-018 STEP_Y: one cycle; the shared adder updates y and vy of the current ball; next state is STEP_X with index+1, or DONE if index = NUM_BALLS-1.
REQ-019 DONE: one cycle; frame_done=1; next state is IDLE; busy is low from DONE onward.
REQ-020 A sweep takes exactly 2*NUM_BALLS+1 cycles from leaving IDLE to returning to IDLE; busy is high for 2*NUM_BALLS cycles.
REQ-021 Axis step: next_p = p + (v arithmetic-shifted right by 2, sign-extended to 10 bits), mod 2^10; p <= next_p.
REQ-022 Velocity step: v <= v + 1 if next_p < (LIMIT-BALL_SIZE)/2, otherwise v - 1; the comparison is unsigned, the arithmetic is 10-bit two's complement with wrap; LIMIT = SCREEN_WIDTH for x and SCREEN_HEIGHT for y.
REQ-023 Negative velocity shifts floor toward minus infinity (v=-1 gives a step of -1).
REQ-024 A trigger while busy or in DONE is ignored for sequencing and sets overrun=1; overrun stays high until reset.
REQ-025 A state-file write becomes visible on rd_x/rd_y in the cycle after the write edge; no other shadowing is applied.
REQ-026 Out-of-range rd_idx (>= NUM_BALLS) returns rd_x=0 and rd_y=0.

Reset
REQ-027 Reset forces state IDLE, index 0, busy=0, frame_done=0, overrun=0, and v_sync_q=1.
REQ-028 Reset sets ball i to x=(SCREEN_WIDTH-BALL_SIZE)*(i+1)/(NUM_BALLS+1) and y=(SCREEN_HEIGHT-BALL_SIZE)*(i+1)/(NUM_BALLS+1), using integer division, with vx=vy=0.
REQ-029 Reset asserted mid-sweep aborts the sweep and restores all REQ-028 values in the same edge; partial updates are discarded.
REQ-030 A trigger in the first cycle after reset deasserts is honoured; v_sync_q=1 makes a low v_sync a valid falling edge.

Configuration
REQ-031 Macro BALL_PAUSE_EN: when defined, the block adds an input port pause (1 bit); a trigger seen while pause=1 goes IDLE->DONE directly, with no state-file change, frame_done still pulsing and busy never rising.
REQ-032 Without BALL_PAUSE_EN, the pause port does not exist and every trigger taken in IDLE runs a full sweep.

Verification
REQ-033 Reset with defaults, rd_idx=0 -> rd_x=134, rd_y=94; rd_idx=3 -> rd_x=537, rd_y=377; busy=0, overrun=0.
REQ-034 One v_sync falling edge with defaults -> busy high exactly 8 cycles, frame_done pulses 1 cycle; ball0 x=134, vx=1, y=94, vy=1.
REQ-035 Five triggers on ball0 -> x stays 134 through frame 4 and reads 135 after frame 5; vx=5.
REQ-036 Force ball0 to x=400, vx=0 -> after one sweep, vx=-1 (0x3FF); after the next sweep, x=399.
REQ-037 Second falling edge 3 cycles after the first -> the sweep still ends after 8 busy cycles and overrun=1 stays high until reset.
REQ-038 Reset pulsed 4 cycles into a sweep -> state returns to IDLE and all positions equal the REQ-033 values; with BALL_PAUSE_EN and pause=1, a trigger gives a frame_done pulse with positions unchanged.

Source files
------------

// File: rtl/ball_sequencer.sv
// ---------------------------------------------------------------------------
// ball_sequencer
//   Once per video frame, moves a small set of bouncing balls. Each ball has a
//   position and a velocity per axis, kept in an internal state file. The
//   falling edge of v_sync starts an update sweep. The sweep takes two cycles
//   per ball: x in one cycle, then y. One shared adder does the arithmetic.
//   Each velocity is pulled toward the centre of the travel range, so every
//   ball oscillates about the middle of the screen.
//
//   Optional feature: define BALL_PAUSE_EN to add the 'pause' input. A trigger
//   that arrives while pause=1 skips the sweep. It only pulses frame_done.
//
// Ports
//   clk_50mhz  in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   v_sync     in   active-low vertical sync, synchronous to clk_50mhz
//   pause      in   (BALL_PAUSE_EN only) skip the position update
//   rd_idx     in   [2:0] ball index for the read port
//   rd_x       out  [9:0] committed x of ball rd_idx (0 if out of range)
//   rd_y       out  [9:0] committed y of ball rd_idx (0 if out of range)
//   busy       out  high while the sweep is stepping balls
//   frame_done out  one-cycle pulse at the end of a sweep
//   overrun    out  sticky: a trigger arrived while a sweep was running
// ---------------------------------------------------------------------------
module ball_sequencer #(
   parameter int NUM_BALLS     = 4,
   parameter int SCREEN_WIDTH  = 800,
   parameter int SCREEN_HEIGHT = 600,
   parameter int BALL_SIZE     = 128
) (
   input  logic       clk_50mhz,
   input  logic       reset,
   input  logic       v_sync,
`ifdef BALL_PAUSE_EN
   input  logic       pause,
`endif
   input  logic [2:0] rd_idx,
   output logic [9:0] rd_x,
   output logic [9:0] rd_y,
   output logic       busy,
   output logic       frame_done,
   output logic       overrun
);

   typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y, DONE} state_t;

   localparam logic [3:0] NB       = 4'(NUM_BALLS);
   localparam logic [2:0] LAST_IDX = 3'(NUM_BALLS - 1);
   localparam logic [9:0] HALF_X   = 10'((SCREEN_WIDTH - BALL_SIZE) / 2);
   localparam logic [9:0] HALF_Y   = 10'((SCREEN_HEIGHT - BALL_SIZE) / 2);

   // The reset position spreads the balls evenly along the diagonal.
   function automatic logic [9:0] home(input int extent, input int i);
      return 10'((extent - BALL_SIZE) * (i + 1) / (NUM_BALLS + 1));
   endfunction

   state_t     state, state_d;
   logic [2:0] idx, idx_d;
   logic       v_sync_q;
   logic       trigger;

   // The state file always has 8 entries, so the 3-bit index needs no resizing.
   // Entries at NUM_BALLS and above are never written and stay at zero.
   logic [9:0] pos_x [8];
   logic [9:0] pos_y [8];
   logic [9:0] vel_x [8];
   logic [9:0] vel_y [8];

   logic [9:0] cur_p, cur_v, half, step, next_p, next_v;

   assign trigger = v_sync_q & ~v_sync;

   // ---------------- FSM: state register ----------------
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk_50mhz) begin
      if (reset) begin
         state    <= IDLE;
         idx      <= '0;
         v_sync_q <= 1'b1;   // a low v_sync right after reset counts as an edge
         overrun  <= 1'b0;
      end else begin
         state    <= state_d;
         idx      <= idx_d;
         v_sync_q <= v_sync;
         if (trigger && state != IDLE)
            overrun <= 1'b1;
      end
   end

   // ---------------- FSM: next state and outputs ----------------
   // NOTE: every signal driven here gets a default first. A missing assignment
   // on any path would infer a latch.
   always_comb begin
      state_d    = state;
      idx_d      = idx;
      busy       = 1'b0;
      frame_done = 1'b0;
      unique case (state)
         IDLE: begin
            if (trigger) begin
`ifdef BALL_PAUSE_EN
               state_d = pause ? DONE : STEP_X;
`else
               state_d = STEP_X;
`endif
               idx_d = '0;
            end
         end
         STEP_X: begin
            busy    = 1'b1;
            state_d = STEP_Y;
         end
         STEP_Y: begin
            busy = 1'b1;
            if (idx == LAST_IDX) begin
               state_d = DONE;
            end else begin
               state_d = STEP_X;
               idx_d   = idx + 3'd1;
            end
         end
         DONE: begin
            frame_done = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- Shared axis adder ----------------
   // The same datapath serves x in STEP_X and y in STEP_Y. The arithmetic
   // shift rounds toward minus infinity, so v=-1 still moves the ball by -1.
   always_comb begin
      cur_p = pos_x[idx];
      cur_v = vel_x[idx];
      half  = HALF_X;
      if (state == STEP_Y) begin
         cur_p = pos_y[idx];
         cur_v = vel_y[idx];
         half  = HALF_Y;
      end
      step   = $unsigned($signed(cur_v) >>> 2);
      next_p = cur_p + step;
      next_v = (next_p < half) ? cur_v + 10'd1 : cur_v - 10'd1;
   end

   // ---------------- State file ----------------
   // NOTE: this storage is deliberately reset. The balls must restart from
   // known home positions, and a reset in mid-sweep throws away any partial
   // update. That rules out a reset-less RAM here.
   always_ff @(posedge clk_50mhz) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            pos_x[i] <= (i < NUM_BALLS) ? home(SCREEN_WIDTH, i)  : '0;
            pos_y[i] <= (i < NUM_BALLS) ? home(SCREEN_HEIGHT, i) : '0;
            vel_x[i] <= '0;
            vel_y[i] <= '0;
         end
      end else if (state == STEP_X) begin
         pos_x[idx] <= next_p;
         vel_x[idx] <= next_v;
      end else if (state == STEP_Y) begin
         pos_y[idx] <= next_p;
         vel_y[idx] <= next_v;
      end
   end

   // ---------------- Read port ----------------
   always_comb begin
      rd_x = '0;
      rd_y = '0;
      if ({1'b0, rd_idx} < NB) begin
         rd_x = pos_x[rd_idx];
         rd_y = pos_y[rd_idx];
      end
   end

endmodule
